sbn_engine: RTL and testbench
=============================

# sbn_engine

Parametrised next-generation subtract-and-branch-if-negative (SBN) execution core. It holds its own instruction memory and register file, both host-loadable while the core is idle. It runs programs under a start/done handshake, with optional single-step mode and a step-limit watchdog, and reports a halt reason. It sits behind the host register interface in place of the fixed-width SBN datapath.

## Interface
- DATA_WIDTH, 16: register and ALU width, ≥8.
- NUM_REGS, 32: register count, power of two, 2..256; R0 reads 0 and is never written.
- IMEM_DEPTH, 32: instruction words, power of two, 2..256.
- CNT_WIDTH, 16: width of instruction counter and step limit.
- clk  in  1: the only clock.
- reset  in  1: synchronous, active-high.
- start  in  1: one-cycle pulse; begins execution at IP 0.
- abort  in  1: host abort while busy.
- step_mode  in  1: when 1, one instruction per `step` pulse.
- step  in  1: advance pulse in step mode.
- step_limit  in  CNT_WIDTH: 0 = unlimited; otherwise maximum instructions per run.
- imem_we  in  1, imem_addr  in  log2(IMEM_DEPTH), imem_wdata  in  32: instruction load port.
- reg_we  in  1, reg_addr  in  log2(NUM_REGS), reg_wdata  in  DATA_WIDTH: host register write.
- reg_rdata  out  DATA_WIDTH: combinational read of reg_addr; 0 for R0.
- busy  out  1: in RUN state.
- done  out  1: run finished; held until next start or reset.
- halt_reason  out  2: 0 none, 1 halt instruction, 2 step limit, 3 abort.
- ip  out  log2(IMEM_DEPTH): current instruction pointer.
- instr_count  out  CNT_WIDTH: instructions executed this run, saturating.

## Operation
- Instruction word fields:
  - [7:0] subtrahend operand; [15:8] minuend operand.
  - [23:16] destination register; the low log2(NUM_REGS) bits are used.
  - [24] subtrahend is a constant; [25] minuend is a constant.
  - [27:26] reserved, ignored.
  - [31:28] signed branch offset, −8..+7.
- Operand resolution:
  - Constant operand: 8-bit field sign-extended to DATA_WIDTH.
  - Register operand: RF[field mod NUM_REGS].
- diff = minuend − subtrahend, modulo 2^DATA_WIDTH.
- Write-back: RF[dest] ← diff unless dest = 0.
- Next IP: (ip + sext(offset)) mod IMEM_DEPTH if diff[DATA_WIDTH−1] = 1; otherwise (ip + 1) mod IMEM_DEPTH.
- Halt instruction: the all-zero word. It counts as executed, writes nothing, does not move ip, and ends the run with reason 1.
- States:
  - IDLE: after reset.
  - RUN.
  - DONE.
- Transitions:
  - IDLE/DONE + start → RUN. ip, instr_count, done and halt_reason are cleared. The register file and IMEM are kept.
  - RUN → DONE on halt instruction (reason 1).
  - RUN → DONE when instr_count reaches a nonzero step_limit after an execute (reason 2).
  - RUN → DONE on abort (reason 3). No instruction executes in the abort cycle.
  - In DONE, a start pulse reruns the program.
- Execution gating: in RUN, an instruction executes each cycle if step_mode = 0, else only in cycles with step = 1.
- Host port gating:
  - imem_we and reg_we take effect only in IDLE or DONE; they are ignored in RUN.
  - reg_rdata is valid in all states.
- instr_count saturates at all-ones.

## Timing
- Reset: state IDLE; busy 0, done 0, halt_reason 0, ip 0, instr_count 0; all registers 0. IMEM contents are not reset.
- start sampled in cycle N: busy = 1 at N+1. The first instruction executes at the N+1 edge, or at the first step pulse in step mode.
- Throughput: 1 instruction/clock. RF write, ip update and count update are all visible the cycle after execution.
- A register written in cycle k is read by the instruction in cycle k+1 without hazard. Write-back is through the register file, with no bypass needed.
- Terminating execute at edge M: done = 1, busy = 0 and halt_reason are valid after edge M.
- start while busy: ignored. abort while not busy: ignored.
- abort and start in the same cycle:
  - In RUN, abort wins.
  - In IDLE/DONE, start wins and abort is ignored.
- Same cycle as an executing instruction: the halt instruction takes priority over the step limit.
- Host write and start in the same cycle: the write is applied, then the run begins with the written value.
- reset asserted mid-run: immediate return to IDLE with all reset values. Any pending write-back is discarded.

## Test plan
- Basic subtract: R1=10, R2=3 loaded; IMEM[0]={dest 3, min R1, sub R2}, IMEM[1]=0; start → R3=7, done, reason 1, instr_count 2, ip 1.
- Branch with wrap: IMEM_DEPTH 32; IMEM[0] is a constant 0−1 into R5 with offset −2, IMEM[30]=0 → branch taken, ip 30, R5 = all-ones, done after 2 instructions.
- Step limit: two-instruction infinite loop, step_limit=100 → done at exactly 100 instructions, reason 2, busy 0.
- Step mode: step_mode=1, three pulses spaced 5 cycles apart → ip advances only on pulse cycles; instr_count 1, 2, 3.
- Abort and gating: abort at cycle 20 of a loop → reason 3. reg_we to R4 during the run is ignored, so R4 keeps its value. A write to R0 is ignored, so reg_rdata stays 0.
- Reset mid-run: reset at cycle 7 → all outputs and registers at reset values next cycle. A rerun from start then reproduces the first-test result.

Source files
------------

// File: rtl/sbn_engine_if.sv
// Host-side bundle for sbn_engine: run control, program/register load ports and status.
// The master drives control and load ports; the slave (engine) drives status.
interface sbn_engine_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 32,
  parameter int IMEM_DEPTH = 32,
  parameter int CNT_WIDTH  = 16
);
  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int RW = $clog2(NUM_REGS);

  logic                  start;
  logic                  abort;
  logic                  step_mode;
  logic                  step;
  logic [CNT_WIDTH-1:0]  step_limit;
  logic                  imem_we;
  logic [AW-1:0]         imem_addr;
  logic [31:0]           imem_wdata;
  logic                  reg_we;
  logic [RW-1:0]         reg_addr;
  logic [DATA_WIDTH-1:0] reg_wdata;
  logic [DATA_WIDTH-1:0] reg_rdata;
  logic                  busy;
  logic                  done;
  logic [1:0]            halt_reason;
  logic [AW-1:0]         ip;
  logic [CNT_WIDTH-1:0]  instr_count;

  modport master (
    output start, abort, step_mode, step, step_limit,
    output imem_we, imem_addr, imem_wdata, reg_we, reg_addr, reg_wdata,
    input  reg_rdata, busy, done, halt_reason, ip, instr_count
  );

  modport slave (
    input  start, abort, step_mode, step, step_limit,
    input  imem_we, imem_addr, imem_wdata, reg_we, reg_addr, reg_wdata,
    output reg_rdata, busy, done, halt_reason, ip, instr_count
  );
endinterface

// File: rtl/sbn_engine.sv
// Subtract-and-branch-if-negative core with private IMEM and register file,
// start/done run control, single-step mode and a step-limit watchdog.
module sbn_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 32,
  parameter int IMEM_DEPTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input logic        clk,
  input logic        reset,
  sbn_engine_if.slave bus
);
  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int RW = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                state_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic [1:0]            reason_reg;
  logic [AW-1:0]         ip_reg;
  logic [CNT_WIDTH-1:0]  count_reg;

  logic [31:0]           imem [IMEM_DEPTH];
  logic [DATA_WIDTH-1:0] rf [NUM_REGS];

  logic                  host_ok;
  logic                  host_wr;
  logic [31:0]           instr;
  logic                  is_halt;
  logic [RW-1:0]         sub_sel;
  logic [RW-1:0]         min_sel;
  logic [RW-1:0]         dest_sel;
  logic [DATA_WIDTH-1:0] sub_val;
  logic [DATA_WIDTH-1:0] min_val;
  logic [DATA_WIDTH-1:0] diff;
  logic [AW-1:0]         ip_next;
  logic                  exec;
  logic                  ex_wr;
  logic [CNT_WIDTH-1:0]  count_next;
  logic                  limit_hit;

  assign host_ok = (state_reg != S_RUN);
  assign host_wr = bus.reg_we && host_ok;

  // IMEM is deliberately left out of reset so a loaded program survives it.
  always_ff @(posedge clk) begin
    if (bus.imem_we && host_ok) begin
      imem[bus.imem_addr] <= bus.imem_wdata;
    end
  end

  assign instr    = imem[ip_reg];
  assign is_halt  = (instr == 32'd0);
  assign sub_sel  = instr[RW-1:0];
  assign min_sel  = instr[8 +: RW];
  assign dest_sel = instr[16 +: RW];

  assign sub_val = instr[24] ? DATA_WIDTH'($signed(instr[7:0]))  : rf[sub_sel];
  assign min_val = instr[25] ? DATA_WIDTH'($signed(instr[15:8])) : rf[min_sel];
  assign diff    = min_val - sub_val;

  // Truncating the sign-extended offset to AW bits gives the modulo-depth wrap.
  assign ip_next = diff[DATA_WIDTH-1] ? ip_reg + AW'($signed(instr[31:28]))
                                      : ip_reg + AW'(1);

  assign exec  = (state_reg == S_RUN) && !bus.abort && (!bus.step_mode || bus.step);
  assign ex_wr = exec && !is_halt && (dest_sel != '0);

  assign count_next = (count_reg == '1) ? count_reg : count_reg + CNT_WIDTH'(1);
  assign limit_hit  = (bus.step_limit != '0) && (count_next == bus.step_limit);

  // R0 has no storage; every other register is its own resettable flop word.
  assign rf[0] = '0;
  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_rf
      logic [DATA_WIDTH-1:0] q_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          q_reg <= '0;
        end else if (host_wr && (bus.reg_addr == RW'(gi))) begin
          q_reg <= bus.reg_wdata;
        end else if (ex_wr && (dest_sel == RW'(gi))) begin
          q_reg <= diff;
        end
      end
      assign rf[gi] = q_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      reason_reg <= 2'd0;
      ip_reg     <= '0;
      count_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_reg  <= S_RUN;
            busy_reg   <= 1'b1;
            done_reg   <= 1'b0;
            reason_reg <= 2'd0;
            ip_reg     <= '0;
            count_reg  <= '0;
          end
        end
        S_RUN: begin
          if (bus.abort) begin
            state_reg  <= S_DONE;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
            reason_reg <= 2'd3;
          end else if (exec) begin
            count_reg <= count_next;
            // A halt outranks the step limit when both land on the same execute.
            if (is_halt) begin
              state_reg  <= S_DONE;
              busy_reg   <= 1'b0;
              done_reg   <= 1'b1;
              reason_reg <= 2'd1;
            end else begin
              ip_reg <= ip_next;
              if (limit_hit) begin
                state_reg  <= S_DONE;
                busy_reg   <= 1'b0;
                done_reg   <= 1'b1;
                reason_reg <= 2'd2;
              end
            end
          end
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.reg_rdata   = rf[bus.reg_addr];
  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.halt_reason = reason_reg;
  assign bus.ip          = ip_reg;
  assign bus.instr_count = count_reg;
endmodule

// File: tb/tb_sbn_engine.sv
// Directed bench for sbn_engine: stimulus pushes expected run results into a
// scoreboard queue; a monitor checks them each time done rises.
module tb_sbn_engine;
  localparam int DW = 16;
  localparam int NR = 32;
  localparam int ID = 32;
  localparam int CW = 16;

  typedef struct {
    logic [1:0]  reason;
    logic [15:0] count;
    logic [4:0]  ip;
    logic [15:0] rval;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   runs = 0;
  exp_t sbq[$];
  logic done_q = 1'b0;

  sbn_engine_if #(.DATA_WIDTH(DW), .NUM_REGS(NR), .IMEM_DEPTH(ID), .CNT_WIDTH(CW)) bus ();

  sbn_engine #(.DATA_WIDTH(DW), .NUM_REGS(NR), .IMEM_DEPTH(ID), .CNT_WIDTH(CW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ins(input int off, input bit mc, input bit sc,
                                      input int dest, input int mn, input int sb);
    logic [31:0] w;
    w = {off[3:0], 2'b00, mc, sc, dest[7:0], mn[7:0], sb[7:0]};
    return w;
  endfunction

  // Monitor: one scoreboard entry consumed per rising done.
  always @(negedge clk) begin
    exp_t e;
    if (bus.done && !done_q) begin
      runs++;
      $display("run %0d: reason=%0d count=%0d ip=%0d reg=%0h", runs,
               bus.halt_reason, bus.instr_count, bus.ip, bus.reg_rdata);
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("run_reason", 32'(bus.halt_reason), 32'(e.reason));
        chk("run_count", 32'(bus.instr_count), 32'(e.count));
        chk("run_ip", 32'(bus.ip), 32'(e.ip));
        chk("run_reg", 32'(bus.reg_rdata), 32'(e.rval));
        chk("run_busy", 32'(bus.busy), 32'd0);
      end
    end
    done_q = bus.done;
  end

  task automatic imem_wr(input int a, input logic [31:0] d);
    @(posedge clk) #1;
    bus.imem_we = 1'b1; bus.imem_addr = 5'(a); bus.imem_wdata = d;
    @(posedge clk) #1;
    bus.imem_we = 1'b0;
  endtask

  task automatic reg_wr(input int a, input logic [15:0] d);
    @(posedge clk) #1;
    bus.reg_we = 1'b1; bus.reg_addr = 5'(a); bus.reg_wdata = d;
    @(posedge clk) #1;
    bus.reg_we = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk) #1;
    bus.start = 1'b1;
    @(posedge clk) #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int n = 0;
    while (!bus.done && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) chk(name, 32'd0, 32'd1);
  endtask

  task automatic push(input int r, input int c, input int ipv, input int rv);
    exp_t e;
    e.reason = 2'(r); e.count = 16'(c); e.ip = 5'(ipv); e.rval = 16'(rv);
    sbq.push_back(e);
  endtask

  task automatic load_loop();
    imem_wr(0, ins(1, 1, 1, 0, 0, 1));
    imem_wr(1, ins(-1, 1, 1, 6, 0, 1));
  endtask

  initial begin
    bus.start = 0; bus.abort = 0; bus.step_mode = 0; bus.step = 0; bus.step_limit = '0;
    bus.imem_we = 0; bus.imem_addr = '0; bus.imem_wdata = '0;
    bus.reg_we = 0; bus.reg_addr = '0; bus.reg_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    bus.reg_addr = 5'd1;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_reason", 32'(bus.halt_reason), 32'd0);
    chk("rst_ip", 32'(bus.ip), 32'd0);
    chk("rst_count", 32'(bus.instr_count), 32'd0);
    chk("rst_r1", 32'(bus.reg_rdata), 32'd0);
    for (int i = 0; i < ID; i++) imem_wr(i, 32'd0);

    // Basic subtract: R3 = R1 - R2 = 7, then halt.
    reg_wr(1, 16'd10);
    reg_wr(2, 16'd3);
    imem_wr(0, ins(0, 0, 0, 3, 1, 2));
    imem_wr(1, 32'd0);
    bus.reg_addr = 5'd3;
    push(1, 2, 1, 16'd7);
    pulse_start();
    wait_done("basic_timeout", 20);

    // Branch backwards from 0 by 2 wraps to 30.
    imem_wr(0, ins(-2, 1, 1, 5, 0, 1));
    imem_wr(30, 32'd0);
    bus.reg_addr = 5'd5;
    push(1, 2, 30, 16'hFFFF);
    pulse_start();
    wait_done("wrap_timeout", 20);

    // Step limit on an endless two-instruction loop.
    load_loop();
    bus.step_limit = 16'd100;
    bus.reg_addr = 5'd6;
    push(2, 100, 0, 16'hFFFF);
    pulse_start();
    wait_done("limit_timeout", 200);

    // Single-step: three pulses, state held between them, then abort.
    bus.step_limit = '0;
    bus.step_mode = 1'b1;
    pulse_start();
    repeat (3) @(negedge clk);
    chk("step_busy", 32'(bus.busy), 32'd1);
    chk("step_cnt0", 32'(bus.instr_count), 32'd0);
    for (int p = 1; p <= 3; p++) begin
      @(posedge clk) #1 bus.step = 1'b1;
      @(posedge clk) #1 bus.step = 1'b0;
      @(negedge clk);
      chk("step_cnt", 32'(bus.instr_count), 32'(p));
      chk("step_ip", 32'(bus.ip), 32'(p % 2));
      repeat (4) @(negedge clk);
      chk("step_hold", 32'(bus.instr_count), 32'(p));
    end
    push(3, 3, 1, 16'hFFFF);
    @(posedge clk) #1 bus.abort = 1'b1;
    @(posedge clk) #1 bus.abort = 1'b0;
    wait_done("step_timeout", 10);
    bus.step_mode = 1'b0;

    // Abort (together with start) at cycle 20; R4 write during the run is dropped.
    reg_wr(4, 16'h1234);
    bus.reg_addr = 5'd4;
    push(3, 20, 0, 16'h1234);
    pulse_start();
    repeat (10) @(posedge clk);
    #1 bus.reg_we = 1'b1; bus.reg_addr = 5'd4; bus.reg_wdata = 16'hBEEF;
    @(posedge clk) #1 bus.reg_we = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.abort = 1'b1; bus.start = 1'b1;
    @(posedge clk) #1 bus.abort = 1'b0; bus.start = 1'b0;
    wait_done("abort_timeout", 10);
    reg_wr(0, 16'h0005);
    @(negedge clk);
    chk("r0_zero", 32'(bus.reg_rdata), 32'd0);
    @(posedge clk) #1 bus.abort = 1'b1;
    @(posedge clk) #1 bus.abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_reason", 32'(bus.halt_reason), 32'd3);
    chk("idle_abort_done", 32'(bus.done), 32'd1);

    // Reset mid-run, then rerun the first program.
    pulse_start();
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk) #1 reset = 1'b0;
    bus.reg_addr = 5'd6;
    @(negedge clk);
    chk("mid_busy", 32'(bus.busy), 32'd0);
    chk("mid_done", 32'(bus.done), 32'd0);
    chk("mid_reason", 32'(bus.halt_reason), 32'd0);
    chk("mid_ip", 32'(bus.ip), 32'd0);
    chk("mid_count", 32'(bus.instr_count), 32'd0);
    chk("mid_r6", 32'(bus.reg_rdata), 32'd0);
    reg_wr(1, 16'd10);
    reg_wr(2, 16'd3);
    imem_wr(0, ins(0, 0, 0, 3, 1, 2));
    imem_wr(1, 32'd0);
    bus.reg_addr = 5'd3;
    push(1, 2, 1, 16'd7);
    pulse_start();
    wait_done("rerun_timeout", 20);

    // Halt beats a step limit reached on the same execute; host write lands with start.
    bus.step_limit = 16'd2;
    push(1, 2, 1, 16'd5);
    @(posedge clk) #1;
    bus.reg_we = 1'b1; bus.reg_addr = 5'd2; bus.reg_wdata = 16'd5; bus.start = 1'b1;
    @(posedge clk) #1;
    bus.reg_we = 1'b0; bus.start = 1'b0; bus.reg_addr = 5'd3;
    wait_done("prio_timeout", 20);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
